// File: rtl/lvds_frame_serializer_pkg.sv
// ser_pkg: shared types and frame-geometry helpers for lvds_frame_serializer.
//   ser_state_t    : IDLE (lanes parked at 0) / RUN (frames being shifted out)
//   ser_beats      : beats per frame, ceil(data_w / lanes)
//   ser_frame_hi   : beats per frame with daframe high, ceil(beats / 2)
package ser_pkg;

  typedef enum logic {SER_IDLE, SER_RUN} ser_state_t;

  function automatic int unsigned ser_beats(input int unsigned data_w,
                                            input int unsigned lanes);
    return (data_w + lanes - 1) / lanes;
  endfunction

  function automatic int unsigned ser_frame_hi(input int unsigned beats);
    return (beats + 1) / 2;
  endfunction

endpackage

// File: rtl/lvds_frame_serializer_clk_phase.sv
// ser_clk_phase: phase counter for the forwarded DAC clock.
//   clk, reset_n : system clock, asynchronous active-low reset
//   strobe       : high on the last phase; the next edge is a daclk rising edge
//   daclk        : registered forwarded clock, period 2*CLK_DIV clk
module ser_clk_phase #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  output logic strobe,
  output logic daclk
);

  localparam int unsigned PERIOD = 2 * CLK_DIV;
  localparam int unsigned PH_W   = $clog2(PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_FALL = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] ph_q, ph_d;
  logic            daclk_q, daclk_d;

  always_comb begin
    strobe  = (ph_q == PH_LAST);
    ph_d    = strobe ? '0 : ph_q + PH_W'(1);
    daclk_d = daclk_q;
    if (strobe) begin
      daclk_d = 1'b1;
    end else if (ph_q == PH_FALL) begin
      daclk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q    <= '0;
      daclk_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      daclk_q <= daclk_d;
    end
  end

  assign daclk = daclk_q;

endmodule

// File: rtl/lvds_frame_serializer.sv
// lvds_frame_serializer: buffers one parallel sample word and shifts it out
// MSB-first across LANES lanes with a frame marker and forwarded DAC clock.
//   clk, reset_n      : system clock, asynchronous active-low reset
//   en                : run enable, sampled at frame boundaries
//   s_data/s_valid/s_ready : one-entry input handshake
//   da, daframe, daclk : serial lanes, frame marker, forwarded clock
//   underrun          : one-clk pulse when a frame starts with nothing buffered
//   underrun_sticky   : set by underrun, cleared only by reset
// Optional: define SER_TEST_PATTERN_EN to add tp_mode, which replaces the
// buffered word with an incrementing ramp on every frame.
module lvds_frame_serializer
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned LANES   = 4,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
`ifdef SER_TEST_PATTERN_EN
  input  logic              tp_mode,
`endif
  output logic              s_ready,
  output logic [LANES-1:0]  da,
  output logic              daframe,
  output logic              daclk,
  output logic              underrun,
  output logic              underrun_sticky
);

  localparam int unsigned BEATS    = ser_beats(DATA_W, LANES);
  localparam int unsigned FRAME_HI = ser_frame_hi(BEATS);
  localparam int unsigned PAD_W    = BEATS * LANES;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Lane bits for beat b of word w, after LSB zero-padding to PAD_W bits.
  function automatic logic [LANES-1:0] beat_bits(input logic [DATA_W-1:0] w,
                                                 input int unsigned b);
    logic [PAD_W-1:0] p;
    p = PAD_W'(w) << (PAD_W - DATA_W);
    p = p >> ((BEATS - 1 - b) * LANES);
    return p[LANES-1:0];
  endfunction

  logic strobe;

  ser_clk_phase #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (strobe),
    .daclk   (daclk)
  );

  ser_state_t        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [LANES-1:0]  da_q, da_d;
  logic              daframe_q, daframe_d;
  logic              underrun_q, underrun_d;
  logic              sticky_q, sticky_d;
`ifdef SER_TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp_q, ramp_d;

  assign s_ready = ~hold_valid_q & ~tp_mode;
`else
  assign s_ready = ~hold_valid_q;
`endif

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    da_d         = da_q;
    daframe_d    = daframe_q;
    underrun_d   = 1'b0;
    sticky_d     = sticky_q;
`ifdef SER_TEST_PATTERN_EN
    ramp_d       = ramp_q;
`endif

    // s_ready is low while hold is full, so this never collides with the
    // boundary load below.
    if (s_valid && s_ready) begin
      hold_d       = s_data;
      hold_valid_d = 1'b1;
    end

    if (strobe) begin
      if (beat_q == LAST_BEAT) begin
        if (!en) begin
          state_d   = SER_IDLE;
          da_d      = '0;
          daframe_d = 1'b0;
        end else begin
          state_d = SER_RUN;
`ifdef SER_TEST_PATTERN_EN
          if (tp_mode) begin
            shift_d = ramp_q;
            ramp_d  = ramp_q + DATA_W'(1);
          end else
`endif
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
            sticky_d   = 1'b1;
          end
          // First beat comes from shift_d so a freshly loaded word is
          // driven on the boundary edge itself.
          beat_d    = '0;
          da_d      = beat_bits(shift_d, 0);
          daframe_d = 1'b1;
        end
      end else if (state_q == SER_RUN) begin
        beat_d    = beat_q + BEAT_W'(1);
        da_d      = beat_bits(shift_q, 32'(beat_d));
        daframe_d = (32'(beat_d) < FRAME_HI);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SER_IDLE;
      beat_q       <= LAST_BEAT;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      da_q         <= '0;
      daframe_q    <= 1'b0;
      underrun_q   <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      da_q         <= da_d;
      daframe_q    <= daframe_d;
      underrun_q   <= underrun_d;
      sticky_q     <= sticky_d;
    end
  end

`ifdef SER_TEST_PATTERN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end
`endif

  assign da              = da_q;
  assign daframe         = daframe_q;
  assign underrun        = underrun_q;
  assign underrun_sticky = sticky_q;

endmodule

// File: tb/tb_lvds_frame_serializer.sv
// Scoreboard bench for lvds_frame_serializer, run on two geometries at once:
//   cfg0: DATA_W=14, LANES=4, CLK_DIV=1   cfg1: DATA_W=10, LANES=3, CLK_DIV=2
// A frame-level reference model pushes the expected outputs after every clock
// edge; a monitor pops and compares them on the falling edge.
module tb_lvds_frame_serializer;

  localparam int unsigned DW0 = 14, LN0 = 4, CD0 = 1;
  localparam int unsigned DW1 = 10, LN1 = 3, CD1 = 2;

  typedef struct {
    int unsigned da;
    int unsigned fr;
    int unsigned ck;
    int unsigned ur;
    int unsigned st;
    int unsigned rdy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic           en0 = 1'b0, sv0 = 1'b0, sr0, fr0, ck0, ur0, st0;
  logic [DW0-1:0] sd0 = '0;
  logic [LN0-1:0] da0;
  logic           en1 = 1'b0, sv1 = 1'b0, sr1, fr1, ck1, ur1, st1;
  logic [DW1-1:0] sd1 = '0;
  logic [LN1-1:0] da1;

  always #5 clk = ~clk;

  lvds_frame_serializer #(.DATA_W(DW0), .LANES(LN0), .CLK_DIV(CD0)) dut0 (
    .clk(clk), .reset_n(rst_n), .en(en0), .s_data(sd0), .s_valid(sv0),
`ifdef SER_TEST_PATTERN_EN
    .tp_mode(1'b0),
`endif
    .s_ready(sr0), .da(da0), .daframe(fr0), .daclk(ck0),
    .underrun(ur0), .underrun_sticky(st0)
  );

  lvds_frame_serializer #(.DATA_W(DW1), .LANES(LN1), .CLK_DIV(CD1)) dut1 (
    .clk(clk), .reset_n(rst_n), .en(en1), .s_data(sd1), .s_valid(sv1),
`ifdef SER_TEST_PATTERN_EN
    .tp_mode(1'b0),
`endif
    .s_ready(sr1), .da(da1), .daframe(fr1), .daclk(ck1),
    .underrun(ur1), .underrun_sticky(st1)
  );

  // ---------------- configuration helpers ----------------
  function automatic int unsigned f_dw(input int c); return (c == 0) ? DW0 : DW1; endfunction
  function automatic int unsigned f_ln(input int c); return (c == 0) ? LN0 : LN1; endfunction
  function automatic int unsigned f_cd(input int c); return (c == 0) ? CD0 : CD1; endfunction
  function automatic int unsigned f_beats(input int c);
    return (f_dw(c) + f_ln(c) - 1) / f_ln(c);
  endfunction
  function automatic int unsigned frame_clks(input int c);
    return f_beats(c) * 2 * f_cd(c);
  endfunction

  // Lane value of beat b: pad the word with zeros at the LSB end, then take
  // the b-th LANES-wide digit counting from the top.
  function automatic int unsigned exp_beat(input int c, input int unsigned w,
                                           input int unsigned b);
    int unsigned pad, padded, digit_scale;
    pad         = f_beats(c) * f_ln(c);
    padded      = w * (32'd1 << (pad - f_dw(c)));
    digit_scale = 32'd1 << ((f_beats(c) - 1 - b) * f_ln(c));
    return (padded / digit_scale) % (32'd1 << f_ln(c));
  endfunction

  function automatic logic get_en(input int c);    return (c == 0) ? en0 : en1; endfunction
  function automatic logic get_valid(input int c); return (c == 0) ? sv0 : sv1; endfunction
  function automatic logic get_ready(input int c); return (c == 0) ? sr0 : sr1; endfunction
  function automatic int unsigned get_data(input int c);
    return (c == 0) ? 32'(sd0) : 32'(sd1);
  endfunction

  function automatic obs_t dut_out(input int c);
    obs_t o;
    if (c == 0) begin
      o.da = 32'(da0); o.fr = 32'(fr0); o.ck = 32'(ck0);
      o.ur = 32'(ur0); o.st = 32'(st0); o.rdy = 32'(sr0);
    end else begin
      o.da = 32'(da1); o.fr = 32'(fr1); o.ck = 32'(ck1);
      o.ur = 32'(ur1); o.st = 32'(st1); o.rdy = 32'(sr1);
    end
    return o;
  endfunction

  // ---------------- reference model ----------------
  int unsigned m_t[2], m_pos[2], m_word[2], m_hold[2], m_hv[2];
  int unsigned m_st[2], m_da[2], m_fr[2];
  obs_t q0[$];
  obs_t q1[$];

  task automatic model_step(input int c);
    int unsigned per, nb, fh, acc, ur;
    obs_t e;
    per = 2 * f_cd(c);
    nb  = f_beats(c);
    fh  = (nb + 1) / 2;
    acc = 32'(get_valid(c) && (m_hv[c] == 0));
    ur  = 0;
    if ((m_t[c] % per) == per - 1) begin
      if (m_pos[c] == nb - 1) begin
        if (get_en(c)) begin
          if (m_hv[c] != 0) begin
            m_word[c] = m_hold[c];
            m_hv[c]   = 0;
          end else begin
            ur      = 1;
            m_st[c] = 1;
          end
          m_pos[c] = 0;
          m_da[c]  = exp_beat(c, m_word[c], 0);
          m_fr[c]  = 1;
        end else begin
          m_da[c] = 0;
          m_fr[c] = 0;
        end
      end else begin
        m_pos[c] = m_pos[c] + 1;
        m_da[c]  = exp_beat(c, m_word[c], m_pos[c]);
        m_fr[c]  = 32'(m_pos[c] < fh);
      end
    end
    if (acc != 0) begin
      m_hold[c] = get_data(c);
      m_hv[c]   = 1;
    end
    e.da  = m_da[c];
    e.fr  = m_fr[c];
    e.ck  = 32'((m_t[c] >= per - 1) && (((m_t[c] + 1) % per) < f_cd(c)));
    e.ur  = ur;
    e.st  = m_st[c];
    e.rdy = 32'(m_hv[c] == 0);
    m_t[c] = m_t[c] + 1;
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        m_t[c] = 0; m_pos[c] = f_beats(c) - 1; m_word[c] = 0; m_hold[c] = 0;
        m_hv[c] = 0; m_st[c] = 0; m_da[c] = 0; m_fr[c] = 0;
      end else begin
        model_step(c);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int  n_tests;
  int  n_fail;
  bit  done = 1'b0;
  bit  to_flag[2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int c, input int unsigned act,
                     input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d @%0t: got %0h, expected %0h", nm, c, $time, act, exp);
    end
  endtask

  initial begin
    obs_t o, e;
    bit   have;
    n_tests = 0;
    n_fail  = 0;
    while (!done) begin
      @(negedge clk or negedge rst_n);
      #1;
      for (int c = 0; c < 2; c++) begin
        o = dut_out(c);
        if (!rst_n) begin
          chk("reset_da", c, o.da, 0);
          chk("reset_daframe", c, o.fr, 0);
          chk("reset_daclk", c, o.ck, 0);
          chk("reset_underrun", c, o.ur, 0);
          chk("reset_sticky", c, o.st, 0);
          chk("reset_s_ready", c, o.rdy, 1);
        end else begin
          have = 1'b0;
          if (c == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (c == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (have) begin
            chk("da", c, o.da, e.da);
            chk("daframe", c, o.fr, e.fr);
            chk("daclk", c, o.ck, e.ck);
            chk("underrun", c, o.ur, e.ur);
            chk("underrun_sticky", c, o.st, e.st);
            chk("s_ready", c, o.rdy, e.rdy);
          end
        end
      end
    end
    for (int c = 0; c < 2; c++) chk("stimulus_timeout", c, 32'(to_flag[c]), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic set_en(input int c, input logic v);
    if (c == 0) en0 = v; else en1 = v;
  endtask
  task automatic set_valid(input int c, input logic v);
    if (c == 0) sv0 = v; else sv1 = v;
  endtask
  task automatic set_data(input int c, input int unsigned w);
    if (c == 0) sd0 = DW0'(w); else sd1 = DW1'(w);
  endtask
  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Present a word and return on the falling edge after it is accepted.
  task automatic send(input int c, input int unsigned w);
    logic        rdy;
    int unsigned n;
    set_data(c, w);
    set_valid(c, 1'b1);
    n = 0;
    forever begin
      rdy = get_ready(c);
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 400) begin
        to_flag[c] = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pos(input int c, input int unsigned p, input bit match_word,
                          input int unsigned w);
    int unsigned n;
    n = 0;
    while (!(m_pos[c] == p && (!match_word || m_word[c] == w))) begin
      @(negedge clk);
      n++;
      if (n > 8 * frame_clks(c)) begin
        to_flag[c] = 1'b1;
        break;
      end
    end
  endtask

  task automatic rand_seq(input int c, input int unsigned iters);
    int unsigned r, fc;
    fc = frame_clks(c);
    repeat (iters) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        set_en(c, 1'b1);
        send(c, $urandom);
        set_valid(c, 1'b0);
        wait_cycles($urandom_range(0, fc));
      end else if (r < 8) begin
        set_en(c, 1'b0);
        wait_cycles($urandom_range(1, 3 * fc));
        set_en(c, 1'b1);
      end else begin
        wait_cycles($urandom_range(0, 2 * fc));
      end
    end
  endtask

  task automatic test_seq(input int c);
    int unsigned fc, w0;
    fc = frame_clks(c);
    w0 = (c == 0) ? 32'h2A5C : 32'h3FF;
    set_en(c, 1'b1);
    send(c, w0);
    set_valid(c, 1'b0);
    wait_cycles(3 * fc);
    send(c, 1);
    send(c, 2);
    send(c, 3);
    set_valid(c, 1'b0);
    wait_cycles(3 * fc);
    send(c, 32'h0A3);
    set_valid(c, 1'b0);
    wait_pos(c, 1, 1'b1, 32'h0A3);
    set_en(c, 1'b0);
    send(c, 32'h155);
    set_valid(c, 1'b0);
    wait_cycles(3 * fc);
    set_en(c, 1'b1);
    wait_cycles(3 * fc);
    rand_seq(c, 25);
    set_en(c, 1'b1);
    set_valid(c, 1'b0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    fork
      test_seq(0);
      test_seq(1);
    join
    fork
      send(0, 32'h1234);
      send(1, 32'h2AB);
    join
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    wait_pos(0, 2, 1'b0, 0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cycles(4 * frame_clks(1));
    done = 1'b1;
  end

endmodule
